// File: rtl/pose_controller.sv
// pose_controller: frame-driven 3-axis pose tracker.
// Keys translate x/y/z with a hold-to-accelerate ramp and clamp at +/-POS_MAX;
// one selectable axis auto-spins modulo TWO_PI while running. A pause toggle,
// a home key and an external pose load complete the control set.
module pose_controller #(
    parameter int              WI          = 8,
    parameter int              WF          = 8,
    parameter int              AW          = 12,
    parameter logic [AW-1:0]   ANG_STEP    = 12'h00a,
    parameter logic [AW-1:0]   TWO_PI      = 12'h648,
    parameter int              POS_STEP    = 1 << (WF - 4),
    parameter int              POS_MAX     = 100 << WF,
    parameter int              RAMP_FRAMES = 4
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     frame_clk_rising_edge,
    input  logic [7:0]               keycode,
    input  logic [1:0]               spin_axis,
    input  logic                     load_valid,
    input  logic signed [WI+WF-1:0]  load_x,
    input  logic signed [WI+WF-1:0]  load_y,
    input  logic signed [WI+WF-1:0]  load_z,
    input  logic [AW-1:0]            load_theta,
    output logic                     load_ready,
    output logic [AW-1:0]            theta_x,
    output logic [AW-1:0]            theta_y,
    output logic [AW-1:0]            theta_z,
    output logic signed [WI+WF-1:0]  x,
    output logic signed [WI+WF-1:0]  y,
    output logic signed [WI+WF-1:0]  z,
    output logic                     pose_valid,
    output logic                     paused
);

    localparam int PW = WI + WF;
    localparam int EW = PW + 3;
    localparam int CW = $clog2(2 * RAMP_FRAMES + 1);

    localparam logic signed [EW-1:0] PMAX_E = EW'(POS_MAX);
    localparam logic signed [EW-1:0] PMIN_E = -PMAX_E;
    localparam logic signed [EW-1:0] STEP0  = EW'(POS_STEP);
    localparam logic signed [EW-1:0] STEP1  = EW'(POS_STEP * 2);
    localparam logic signed [EW-1:0] STEP2  = EW'(POS_STEP * 4);
    localparam logic [CW-1:0]        CNT_LO = CW'(RAMP_FRAMES);
    localparam logic [CW-1:0]        CNT_HI = CW'(2 * RAMP_FRAMES);

    typedef enum logic {RUN, PAUSED} state_t;

    // Clamp a widened position back into [-POS_MAX, +POS_MAX].
    function automatic logic signed [PW-1:0] sat(input logic signed [EW-1:0] v);
        if (v > PMAX_E)
            return PMAX_E[PW-1:0];
        else if (v < PMIN_E)
            return PMIN_E[PW-1:0];
        else
            return v[PW-1:0];
    endfunction

    // Sign-extend a position into the guard-bit arithmetic width.
    function automatic logic signed [EW-1:0] ext(input logic signed [PW-1:0] v);
        return {{3{v[PW-1]}}, v};
    endfunction

    state_t                 state;
    logic                   prev_pause_key;
    logic signed [PW-1:0]   pos_q    [3];
    logic signed [PW-1:0]   pos_nxt  [3];
    logic signed [PW-1:0]   load_pos [3];
    logic signed [EW-1:0]   step_e   [3];
    logic [CW-1:0]          cnt_q    [3];
    logic [CW-1:0]          cnt_nxt  [3];
    logic [AW-1:0]          theta_q  [3];
    logic [AW-1:0]          spin_cur;
    logic [AW:0]            spin_sum;
    logic [AW-1:0]          spin_nxt;
    logic [AW-1:0]          load_ang;
    logic                   load_fire;

    // Loads are refused on frame-tick cycles so the two never collide.
    assign load_ready = ~frame_clk_rising_edge;
    assign load_fire  = load_valid & load_ready;

    assign x       = pos_q[0];
    assign y       = pos_q[1];
    assign z       = pos_q[2];
    assign theta_x = theta_q[0];
    assign theta_y = theta_q[1];
    assign theta_z = theta_q[2];

    // Per-axis ramped step, saturating translation and ramp counter update.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            if (cnt_q[i] < CNT_LO)
                step_e[i] = STEP0;
            else if (cnt_q[i] < CNT_HI)
                step_e[i] = STEP1;
            else
                step_e[i] = STEP2;

            // Positive key wins when both directions are held.
            if (keycode[2*i])
                pos_nxt[i] = sat(ext(pos_q[i]) + step_e[i]);
            else if (keycode[2*i+1])
                pos_nxt[i] = sat(ext(pos_q[i]) - step_e[i]);
            else
                pos_nxt[i] = pos_q[i];

            if (keycode[2*i] | keycode[2*i+1])
                cnt_nxt[i] = (cnt_q[i] == CNT_HI) ? CNT_HI : cnt_q[i] + CW'(1);
            else
                cnt_nxt[i] = '0;
        end
    end

    // Clamped load positions and the spin-axis angle arithmetic.
    always_comb begin
        load_pos[0] = sat(ext(load_x));
        load_pos[1] = sat(ext(load_y));
        load_pos[2] = sat(ext(load_z));

        spin_cur = '0;
        for (int i = 0; i < 3; i++) begin
            if (spin_axis == 2'(i))
                spin_cur = theta_q[i];
        end

        // One extra bit keeps the carry so the modulus compare is exact.
        spin_sum = {1'b0, spin_cur} + {1'b0, ANG_STEP};
        if (spin_sum >= {1'b0, TWO_PI})
            spin_nxt = spin_sum[AW-1:0] - TWO_PI;
        else
            spin_nxt = spin_sum[AW-1:0];

        if (load_theta >= TWO_PI)
            load_ang = load_theta - TWO_PI;
        else
            load_ang = load_theta;
    end

    // RUN/PAUSED FSM plus all pose state, updated on frame ticks or accepted loads.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state          <= RUN;
            paused         <= 1'b0;
            prev_pause_key <= 1'b0;
            pose_valid     <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                pos_q[i]   <= '0;
                cnt_q[i]   <= '0;
                theta_q[i] <= '0;
            end
        end else begin
            pose_valid <= frame_clk_rising_edge | load_fire;
            if (frame_clk_rising_edge) begin
                prev_pause_key <= keycode[6];
                if (keycode[7]) begin
                    // Home overrides everything else but leaves the FSM state alone.
                    for (int i = 0; i < 3; i++) begin
                        pos_q[i]   <= '0;
                        cnt_q[i]   <= '0;
                        theta_q[i] <= '0;
                    end
                end else begin
                    if (keycode[6] && !prev_pause_key) begin
                        state  <= (state == RUN) ? PAUSED : RUN;
                        paused <= (state == RUN);
                    end
                    for (int i = 0; i < 3; i++) begin
                        pos_q[i] <= pos_nxt[i];
                        cnt_q[i] <= cnt_nxt[i];
                        // spin_axis == 3 never matches, so no axis spins.
                        if (state == RUN && spin_axis == 2'(i))
                            theta_q[i] <= spin_nxt;
                    end
                end
            end else if (load_fire) begin
                for (int i = 0; i < 3; i++) begin
                    pos_q[i] <= load_pos[i];
                    if (spin_axis == 2'(i))
                        theta_q[i] <= load_ang;
                end
            end
        end
    end

endmodule

// File: tb/tb_pose_controller.sv
// Scoreboard bench for pose_controller: stimulus pushes the expected pose
// computed by a plain-integer model; a negedge monitor pops on pose_valid.
module tb_pose_controller;

    localparam int PMAX = 100 << 8;
    localparam int ANG  = 10;
    localparam int TP   = 1608;

    logic               Clk;
    logic               Reset_n;
    logic               frame_clk_rising_edge;
    logic [7:0]         keycode;
    logic [1:0]         spin_axis;
    logic               load_valid;
    logic signed [15:0] load_x, load_y, load_z;
    logic [11:0]        load_theta;
    logic               load_ready;
    logic [11:0]        theta_x, theta_y, theta_z;
    logic signed [15:0] x, y, z;
    logic               pose_valid;
    logic               paused;

    pose_controller dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk_rising_edge(frame_clk_rising_edge),
        .keycode(keycode), .spin_axis(spin_axis), .load_valid(load_valid),
        .load_x(load_x), .load_y(load_y), .load_z(load_z), .load_theta(load_theta),
        .load_ready(load_ready), .theta_x(theta_x), .theta_y(theta_y), .theta_z(theta_z),
        .x(x), .y(y), .z(z), .pose_valid(pose_valid), .paused(paused)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int px, py, pz, tx, ty, tz;
        int p;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    int   m_pos[3];
    int   m_th[3];
    int   m_cnt[3];
    int   m_paused;
    int   m_prev;

    function automatic int clampi(input int v);
        if (v > PMAX) return PMAX;
        if (v < -PMAX) return -PMAX;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_pos[i] = 0; m_th[i] = 0; m_cnt[i] = 0;
        end
        m_paused = 0;
        m_prev   = 0;
    endtask

    task automatic model_tick(input logic [7:0] k, input int ax);
        int step;
        bit edge_seen;
        edge_seen = (k[6] == 1'b1) && (m_prev == 0);
        m_prev = k[6];
        if (k[7]) begin
            for (int i = 0; i < 3; i++) begin
                m_pos[i] = 0; m_th[i] = 0; m_cnt[i] = 0;
            end
        end else begin
            if (m_paused == 0 && ax != 3) begin
                m_th[ax] = m_th[ax] + ANG;
                if (m_th[ax] >= TP) m_th[ax] = m_th[ax] - TP;
            end
            if (edge_seen) m_paused = 1 - m_paused;
            for (int a = 0; a < 3; a++) begin
                if (m_cnt[a] < 4) step = 16;
                else if (m_cnt[a] < 8) step = 32;
                else step = 64;
                if (k[2*a]) m_pos[a] = clampi(m_pos[a] + step);
                else if (k[2*a+1]) m_pos[a] = clampi(m_pos[a] - step);
                if (k[2*a] || k[2*a+1]) m_cnt[a] = (m_cnt[a] >= 8) ? 8 : m_cnt[a] + 1;
                else m_cnt[a] = 0;
            end
        end
    endtask

    task automatic model_load(input int lx, input int ly, input int lz, input int lt, input int ax);
        m_pos[0] = clampi(lx);
        m_pos[1] = clampi(ly);
        m_pos[2] = clampi(lz);
        if (ax != 3) m_th[ax] = (lt >= TP) ? lt - TP : lt;
    endtask

    task automatic push_exp();
        exp_t e;
        e.px = m_pos[0]; e.py = m_pos[1]; e.pz = m_pos[2];
        e.tx = m_th[0];  e.ty = m_th[1];  e.tz = m_th[2];
        e.p  = m_paused;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic cycle(input bit tk, input logic [7:0] k, input int ax, input bit lv,
                         input int lx, input int ly, input int lz, input int lt);
        frame_clk_rising_edge = tk;
        keycode    = k;
        spin_axis  = 2'(ax);
        load_valid = lv;
        load_x     = 16'(lx);
        load_y     = 16'(ly);
        load_z     = 16'(lz);
        load_theta = 12'(lt);
        #1;
        chk("load_ready", int'(load_ready), int'(!tk));
        if (tk) begin
            model_tick(k, ax);
            push_exp();
        end else if (lv) begin
            model_load(lx, ly, lz, lt, ax);
            push_exp();
        end
        @(posedge Clk);
        #1;
        frame_clk_rising_edge = 1'b0;
        load_valid = 1'b0;
    endtask

    task automatic tick(input logic [7:0] k, input int ax);
        cycle(1'b1, k, ax, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic idle();
        cycle(1'b0, 8'h00, 3, 1'b0, 0, 0, 0, 0);
    endtask

    // Monitor: every pose_valid pulse must match the oldest expected pose.
    always @(negedge Clk) begin
        if (pose_valid) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL pose_pulse: got unexpected pose_valid, expected none (x=%0d y=%0d z=%0d)", x, y, z);
            end else begin
                mon_e = q.pop_front();
                if (int'(x) != mon_e.px || int'(y) != mon_e.py || int'(z) != mon_e.pz ||
                    int'(theta_x) != mon_e.tx || int'(theta_y) != mon_e.ty ||
                    int'(theta_z) != mon_e.tz || int'(paused) != mon_e.p) begin
                    n_fail++;
                    $display("FAIL pose: got x=%0d y=%0d z=%0d tx=%0d ty=%0d tz=%0d p=%0d, expected x=%0d y=%0d z=%0d tx=%0d ty=%0d tz=%0d p=%0d",
                             x, y, z, theta_x, theta_y, theta_z, paused,
                             mon_e.px, mon_e.py, mon_e.pz, mon_e.tx, mon_e.ty, mon_e.tz, mon_e.p);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int cap_th;
        logic [7:0] rk;
        model_reset();
        Reset_n = 1'b0;
        frame_clk_rising_edge = 1'b0;
        keycode = '0; spin_axis = 2'd3; load_valid = 1'b0;
        load_x = '0; load_y = '0; load_z = '0; load_theta = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_x", int'(x), 0);
        chk("reset_theta_x", int'(theta_x), 0);
        chk("reset_pose_valid", int'(pose_valid), 0);
        chk("reset_paused", int'(paused), 0);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // Spin wrap on X
        cycle(1'b0, 8'h00, 0, 1'b1, 0, 0, 0, 12'h640);
        tick(8'h00, 0);
        chk("wrap_theta_x", int'(theta_x), 12'h002);
        chk("wrap_pulse_hi", int'(pose_valid), 1);
        idle();
        chk("wrap_pulse_lo", int'(pose_valid), 0);

        // Ramp: home, then 9 held ticks of x+
        tick(8'h80, 3);
        repeat (9) tick(8'h01, 3);
        chk("ramp_x", int'(x), 16'h0100);

        // Saturation and +/- precedence
        cycle(1'b0, 8'h00, 3, 1'b1, PMAX - 8, 0, 0, 0);
        tick(8'h01, 3);
        chk("sat_pos_x", int'(x), PMAX);
        cycle(1'b0, 8'h00, 3, 1'b1, 0, 0, 0, 0);
        tick(8'h03, 3);
        chk("both_keys_x", int'(x), 64);
        cycle(1'b0, 8'h00, 3, 1'b1, -(PMAX - 10), 0, 0, 0);
        tick(8'h02, 3);
        chk("sat_neg_x", int'(x), -PMAX);

        // Pause: held toggle fires once, angles freeze, translation continues
        tick(8'h40, 1);
        chk("pause_on", int'(paused), 1);
        cap_th = int'(theta_y);
        tick(8'h44, 1);
        tick(8'h44, 1);
        chk("pause_held", int'(paused), 1);
        chk("pause_theta_frozen", int'(theta_y), cap_th);
        chk("pause_y_moves", int'(y), 32);
        tick(8'h00, 1);
        tick(8'h40, 1);
        chk("pause_off", int'(paused), 0);

        // Load refused on a tick, accepted the cycle after
        cycle(1'b1, 8'h00, 2, 1'b1, 5, 6, 7, 12'h650);
        chk("load_refused_x", int'(x), -PMAX);
        cycle(1'b0, 8'h00, 2, 1'b1, 5, 6, 7, 12'h650);
        chk("load_theta_z", int'(theta_z), 12'h008);
        chk("load_x", int'(x), 5);

        // Home overrides translation
        tick(8'h81, 0);
        chk("home_x", int'(x), 0);
        chk("home_theta_z", int'(theta_z), 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rk = 8'($urandom);
            if ($urandom_range(0, 15) != 0) rk[7] = 1'b0;
            cycle($urandom_range(0, 2) != 0, rk, int'($urandom_range(0, 3)),
                  $urandom_range(0, 3) == 0,
                  int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                  int'($signed(16'($urandom))), int'($urandom_range(0, 4095)));
        end
        idle();

        // Reset in the middle of a frame with a pulse in flight
        tick(8'h00, 3);
        if (m_paused == 0) tick(8'h40, 0);
        else tick(8'h00, 0);
        tick(8'h05, 0);
        #2;
        Reset_n = 1'b0;
        #1;
        q.delete();
        model_reset();
        chk("midreset_x", int'(x), 0);
        chk("midreset_theta_x", int'(theta_x), 0);
        chk("midreset_pose_valid", int'(pose_valid), 0);
        chk("midreset_paused", int'(paused), 0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        tick(8'h04, 1);
        chk("fresh_y", int'(y), 16);
        chk("fresh_theta_y", int'(theta_y), ANG);

        idle();
        idle();
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pose_controller.md
POSE_CONTROLLER -- requirements
Module: pose_controller

Interface
REQ-001 Parameter WI, default 8, integer bits of position.
REQ-002 Parameter WF, default 8, fraction bits of position; WF >= 4.
REQ-003 Parameter AW, default 12, angle width, unsigned Q4.(AW-4).
REQ-004 Parameter ANG_STEP, default 12'h00a, spin increment per frame; 0 < ANG_STEP < TWO_PI.
REQ-005 Parameter TWO_PI, default 12'h648, angle modulus; TWO_PI < 2^AW.
REQ-006 Parameter POS_STEP, default 1 << (WF-4), base translation step, i.e. 1/16 unit.
REQ-007 Parameter POS_MAX, default 100 << WF, symmetric position limit, positive.
REQ-008 Parameter RAMP_FRAMES, default 4, held-key frames per speed doubling; >= 1.
REQ-009 Clk  in  1  sole clock; all state updates on rising edge.
REQ-010 Reset_n  in  1  asynchronous, active-low reset.
REQ-011 frame_clk_rising_edge  in  1  one-cycle frame tick.
REQ-012 keycode  in  8  bits 0/1 x+/x-, 2/3 y+/y-, 4/5 z+/z-, 6 pause toggle, 7 home.
REQ-013 spin_axis  in  2  auto-spin axis: 0 X, 1 Y, 2 Z, 3 none.
REQ-014 load_valid  in  1  external pose load request.
REQ-015 load_x, load_y, load_z  in  WI+WF each  signed load positions.
REQ-016 load_theta  in  AW  load value for the spin-axis angle.
REQ-017 load_ready  out  1  load acceptance.
REQ-018 theta_x, theta_y, theta_z  out  AW each  current angles.
REQ-019 x, y, z  out  WI+WF each  signed current positions.
REQ-020 pose_valid  out  1  one-cycle pulse after any pose update.
REQ-021 paused  out  1  high when FSM is in PAUSED.

Function
REQ-022 FSM states: RUN and PAUSED; transitions occur only on frame ticks.
REQ-023 Pause toggle SHALL fire on a frame tick when keycode[6]=1 and keycode[6] was 0 at the previous frame tick; a held bit toggles once.
REQ-024 In RUN, each frame tick adds ANG_STEP to the spin-axis angle: sum computed in AW+1 bits; if sum >= TWO_PI, result = sum - TWO_PI; other angles unchanged.
REQ-025 In PAUSED, or with spin_axis=3, no angle changes; translation remains active.
REQ-026 Per axis per frame tick: + key set adds step; else - key set subtracts step; both set means + wins; neither means no change.
REQ-027 Per-axis ramp counter increments on frame ticks with either key of that axis held, saturates at 2*RAMP_FRAMES, and clears on a frame tick with neither key held.
REQ-028 Step = POS_STEP << s, where s = 0 if cnt < RAMP_FRAMES, s = 1 if cnt < 2*RAMP_FRAMES, else s = 2; cnt is the value before the increment.
REQ-029 Position arithmetic in WI+WF+3 signed bits, result clamped to [-POS_MAX, +POS_MAX]; no wrap.
REQ-030 keycode[7] on a frame tick SHALL home all angles and positions to 0 and clear ramp counters; it overrides translation, spin and pause toggle, and FSM state is kept.
REQ-031 load_ready = NOT frame_clk_rising_edge, so loads never collide with frame updates.
REQ-032 On load_valid AND load_ready: x/y/z take load values clamped to ±POS_MAX; spin-axis angle takes load_theta, and if load_theta >= TWO_PI then load_theta - TWO_PI; with spin_axis=3, no angle is loaded.
REQ-033 pose_valid SHALL pulse high for exactly one cycle, the cycle after a frame tick or an accepted load, even if values did not change.
REQ-034 All outputs are registered; update latency is 1 cycle from tick or load.

Reset
REQ-035 Reset_n low asynchronously clears all angles, positions, ramp counters, previous pause bit and pose_valid to 0, and sets FSM to RUN (paused=0); load_ready follows REQ-031.
REQ-036 Reset mid-operation discards any in-flight load and pending pulse; the first tick after release behaves as a fresh start.

Verification
REQ-037 Spin wrap: spin_axis=0, RUN, theta_x=12'h640, tick -> theta_x=12'h002, pose_valid pulses 1 cycle.
REQ-038 Ramp: keycode[0] held 9 ticks from x=0, defaults -> x = 4*0x10 + 4*0x20 + 1*0x40 = 0x100.
REQ-039 Saturation: x=POS_MAX-0x08, keycode[0] tick -> x=POS_MAX; keycode[0]|keycode[1] both set -> + direction applied.
REQ-040 Pause: keycode[6] held 3 ticks -> paused=1 after the first tick only, angles frozen, keycode[2] still moves y.
REQ-041 Load: load_valid with tick high -> not accepted; next cycle accepted; load_theta=12'h650 -> spin angle=12'h008.
REQ-042 Home and reset: keycode[7]|keycode[0] tick -> all 0; Reset_n low mid-frame -> outputs 0 immediately, paused=0.
